// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: program-level handshake, branch/stall control,
// instruction-memory port and the registered outputs toward the decoder.
interface fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] imem_data;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic [CNT_W-1:0]   fetch_count;
    logic               done;

    // Side that drives control and supplies memory data (environment / pipeline).
    modport master (
        output start, stall, branch_taken, branch_target, imem_data,
        input  imem_addr, instruction, instr_valid, pc, fetch_count, done
    );

    // The fetch unit itself.
    modport slave (
        input  start, stall, branch_taken, branch_target, imem_data,
        output imem_addr, instruction, instr_valid, pc, fetch_count, done
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the fetched instruction for
// the decoder, flushes on taken branches, holds on stall and signals Done when
// the PC reaches PROG_END.
module fetch_unit #(
    parameter int PC_W     = 10,
    parameter int INSTR_W  = 9,
    parameter int PROG_END = 1023,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PROG_END);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic               valid_reg, valid_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               done_reg, done_next;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a branch sampled at PROG_END keeps the program running.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!bus.branch_taken && !bus.stall && (pc_reg == PC_LAST)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values; branch beats stall, stall beats end-of-program.
    always_comb begin
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        valid_next = valid_reg;
        count_next = count_reg;
        done_next  = done_reg;
        case (state_reg)
            IDLE, DONE: begin
                ir_next    = '0;
                valid_next = 1'b0;
                if (bus.start) begin
                    pc_next    = '0;
                    count_next = '0;
                    done_next  = 1'b0;
                end
            end
            RUN: begin
                if (bus.branch_taken) begin
                    pc_next    = bus.branch_target;
                    ir_next    = '0;
                    valid_next = 1'b0;
                end else if (bus.stall) begin
                    // everything holds
                end else if (pc_reg == PC_LAST) begin
                    ir_next    = '0;
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    ir_next    = bus.imem_data;
                    valid_next = 1'b1;
                    pc_next    = pc_reg + PC_W'(1);
                    if (count_reg != CNT_MAX) begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                pc_next    = '0;
                ir_next    = '0;
                valid_next = 1'b0;
                count_next = '0;
                done_next  = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset drops any in-flight fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= '0;
            ir_reg    <= '0;
            valid_reg <= 1'b0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    assign bus.imem_addr   = pc_reg;
    assign bus.pc          = pc_reg;
    assign bus.instruction = ir_reg;
    assign bus.instr_valid = valid_reg;
    assign bus.fetch_count = count_reg;
    assign bus.done        = done_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instance A uses the default PROG_END, B stops
// at PC=8, C stops at PC=3 with a 2-bit counter to reach wrap and saturation.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic       start_a = 0, stall_a = 0, br_a = 0;
    logic [9:0] tgt_a = '0;
    logic       start_b = 0;
    logic       start_c = 0, br_c = 0;
    logic [9:0] tgt_c = '0;

    always #5 clk = ~clk;

    // Instruction memory: four fixed words, then addr[8:0] ^ 9'h0A5.
    function automatic logic [8:0] mem(input logic [9:0] a);
        case (a)
            10'd0:   return 9'h041;
            10'd1:   return 9'h0C8;
            10'd2:   return 9'h1A3;
            10'd3:   return 9'h1FF;
            default: return a[8:0] ^ 9'h0A5;
        endcase
    endfunction

    fetch_unit_if #(.PC_W(10), .INSTR_W(9), .CNT_W(16)) ifa ();
    fetch_unit_if #(.PC_W(10), .INSTR_W(9), .CNT_W(16)) ifb ();
    fetch_unit_if #(.PC_W(10), .INSTR_W(9), .CNT_W(2))  ifc ();

    assign ifa.start = start_a;
    assign ifa.stall = stall_a;
    assign ifa.branch_taken = br_a;
    assign ifa.branch_target = tgt_a;
    assign ifa.imem_data = mem(ifa.imem_addr);

    assign ifb.start = start_b;
    assign ifb.stall = 1'b0;
    assign ifb.branch_taken = 1'b0;
    assign ifb.branch_target = '0;
    assign ifb.imem_data = mem(ifb.imem_addr);

    assign ifc.start = start_c;
    assign ifc.stall = 1'b0;
    assign ifc.branch_taken = br_c;
    assign ifc.branch_target = tgt_c;
    assign ifc.imem_data = mem(ifc.imem_addr);

    fetch_unit #(.PC_W(10), .INSTR_W(9), .PROG_END(1023), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    fetch_unit #(.PC_W(10), .INSTR_W(9), .PROG_END(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));
    fetch_unit #(.PC_W(10), .INSTR_W(9), .PROG_END(3), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    // One clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("%0t A pc=%h ir=%h v=%b d=%b cnt=%0d | B pc=%h d=%b | C pc=%h cnt=%0d d=%b",
                 $time, ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count,
                 ifb.pc, ifb.done, ifc.pc, ifc.fetch_count, ifc.done);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count, ifa.imem_addr} !== 47'd0) begin
            errors++;
            $display("FAIL reset_a pc=%h ir=%h v=%b d=%b cnt=%0d addr=%h want all zero",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count, ifa.imem_addr);
        end
        checks++;
        if ({ifb.pc, ifb.instruction, ifb.instr_valid, ifb.done, ifb.fetch_count,
             ifc.pc, ifc.instruction, ifc.instr_valid, ifc.done, ifc.fetch_count} !== 60'd0) begin
            errors++;
            $display("FAIL reset_bc B pc=%h d=%b cnt=%0d C pc=%h d=%b cnt=%0d want all zero",
                     ifb.pc, ifb.done, ifb.fetch_count, ifc.pc, ifc.done, ifc.fetch_count);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({ifa.pc, ifa.instr_valid, ifa.fetch_count} !== 27'd0) begin
            errors++;
            $display("FAIL idle_hold pc=%h v=%b cnt=%0d want pc=000 v=0 cnt=0",
                     ifa.pc, ifa.instr_valid, ifa.fetch_count);
        end
    endtask

    task automatic test_fetch();
        logic [8:0] words [4] = '{9'h041, 9'h0C8, 9'h1A3, 9'h1FF};
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count} !== {10'h000, 9'h000, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL start pc=%h ir=%h v=%b d=%b cnt=%0d want pc=000 ir=000 v=0 d=0 cnt=0",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count} !==
                {10'(i + 1), words[i], 1'b1, 1'b0, 16'(i + 1)}) begin
                errors++;
                $display("FAIL fetch%0d pc=%h ir=%h v=%b d=%b cnt=%0d want pc=%h ir=%h v=1 d=0 cnt=%0d",
                         i, ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count,
                         10'(i + 1), words[i], i + 1);
            end
        end
    endtask

    task automatic test_stall();
        tick();
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count} !== {10'h005, 9'h0A1, 1'b1, 16'd5}) begin
            errors++;
            $display("FAIL pre_stall pc=%h ir=%h v=%b cnt=%0d want pc=005 ir=0A1 v=1 cnt=5",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count);
        end
        stall_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count} !== {10'h005, 9'h0A1, 1'b1, 16'd5}) begin
                errors++;
                $display("FAIL stall_hold%0d pc=%h ir=%h v=%b cnt=%0d want pc=005 ir=0A1 v=1 cnt=5",
                         k, ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count);
            end
        end
        stall_a = 1'b0;
        tick();
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count} !== {10'h006, 9'h0A0, 1'b1, 16'd6}) begin
            errors++;
            $display("FAIL stall_resume pc=%h ir=%h v=%b cnt=%0d want pc=006 ir=0A0 v=1 cnt=6",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count);
        end
    endtask

    task automatic test_branch();
        tick();
        br_a = 1'b1;
        tgt_a = 10'h020;
        checks++;
        if ({ifa.pc, ifa.instruction} !== {10'h007, 9'h0A3}) begin
            errors++;
            $display("FAIL pre_branch pc=%h ir=%h want pc=007 ir=0A3", ifa.pc, ifa.instruction);
        end
        tick();
        br_a = 1'b0;
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count} !== {10'h020, 9'h000, 1'b0, 16'd7}) begin
            errors++;
            $display("FAIL branch_flush pc=%h ir=%h v=%b cnt=%0d want pc=020 ir=000 v=0 cnt=7",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count);
        end
        tick();
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count} !== {10'h021, 9'h085, 1'b1, 16'd8}) begin
            errors++;
            $display("FAIL branch_target pc=%h ir=%h v=%b cnt=%0d want pc=021 ir=085 v=1 cnt=8",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count);
        end
    endtask

    task automatic test_branch_stall();
        br_a = 1'b1;
        stall_a = 1'b1;
        tgt_a = 10'h100;
        tick();
        br_a = 1'b0;
        stall_a = 1'b0;
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count} !== {10'h100, 9'h000, 1'b0, 16'd8}) begin
            errors++;
            $display("FAIL branch_over_stall pc=%h ir=%h v=%b cnt=%0d want pc=100 ir=000 v=0 cnt=8",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count);
        end
        tick();
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count} !== {10'h101, 9'h1A5, 1'b1, 16'd9}) begin
            errors++;
            $display("FAIL branch_stall_fetch pc=%h ir=%h v=%b cnt=%0d want pc=101 ir=1A5 v=1 cnt=9",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count);
        end
    endtask

    task automatic test_prog_end();
        br_a = 1'b1;
        tgt_a = 10'h3FE;
        tick();
        br_a = 1'b0;
        tick();
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count} !== {10'h3FF, 9'h15B, 1'b1, 16'd10}) begin
            errors++;
            $display("FAIL reach_end pc=%h ir=%h v=%b cnt=%0d want pc=3FF ir=15B v=1 cnt=10",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count);
        end
        br_a = 1'b1;
        tgt_a = 10'h004;
        tick();
        br_a = 1'b0;
        checks++;
        if ({ifa.pc, ifa.instr_valid, ifa.done} !== {10'h004, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL branch_at_end pc=%h v=%b d=%b want pc=004 v=0 d=0",
                     ifa.pc, ifa.instr_valid, ifa.done);
        end
        br_a = 1'b1;
        tgt_a = 10'h3FE;
        tick();
        br_a = 1'b0;
        tick();
        tick();
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count} !== {10'h3FF, 9'h000, 1'b0, 1'b1, 16'd11}) begin
            errors++;
            $display("FAIL done_a pc=%h ir=%h v=%b d=%b cnt=%0d want pc=3FF ir=000 v=0 d=1 cnt=11",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count);
        end
        br_a = 1'b1;
        stall_a = 1'b1;
        tgt_a = 10'h005;
        tick();
        tick();
        br_a = 1'b0;
        stall_a = 1'b0;
        checks++;
        if ({ifa.pc, ifa.instr_valid, ifa.done, ifa.fetch_count} !== {10'h3FF, 1'b0, 1'b1, 16'd11}) begin
            errors++;
            $display("FAIL done_ignores pc=%h v=%b d=%b cnt=%0d want pc=3FF v=0 d=1 cnt=11",
                     ifa.pc, ifa.instr_valid, ifa.done, ifa.fetch_count);
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++;
        if ({ifa.pc, ifa.instr_valid, ifa.done, ifa.fetch_count} !== {10'h000, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL restart_a pc=%h v=%b d=%b cnt=%0d want pc=000 v=0 d=0 cnt=0",
                     ifa.pc, ifa.instr_valid, ifa.done, ifa.fetch_count);
        end
        tick();
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count} !== {10'h001, 9'h041, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL restart_fetch pc=%h ir=%h v=%b cnt=%0d want pc=001 ir=041 v=1 cnt=1",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.fetch_count);
        end
    endtask

    task automatic test_reset_midrun();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count} !== 37'd0) begin
            errors++;
            $display("FAIL async_reset pc=%h ir=%h v=%b d=%b cnt=%0d want all zero",
                     ifa.pc, ifa.instruction, ifa.instr_valid, ifa.done, ifa.fetch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({ifa.pc, ifa.instr_valid, ifa.fetch_count} !== 27'd0) begin
            errors++;
            $display("FAIL post_reset_idle pc=%h v=%b cnt=%0d want pc=000 v=0 cnt=0",
                     ifa.pc, ifa.instr_valid, ifa.fetch_count);
        end
    endtask

    task automatic test_done_restart();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({ifb.pc, ifb.instr_valid, ifb.fetch_count} !== {10'(i + 1), 1'b1, 16'(i + 1)}) begin
                errors++;
                $display("FAIL b_fetch%0d pc=%h v=%b cnt=%0d want pc=%h v=1 cnt=%0d",
                         i, ifb.pc, ifb.instr_valid, ifb.fetch_count, 10'(i + 1), i + 1);
            end
        end
        checks++;
        if (ifb.instruction !== 9'h0A2) begin
            errors++;
            $display("FAIL b_last_ir ir=%h want 0A2", ifb.instruction);
        end
        tick();
        tick();
        checks++;
        if ({ifb.pc, ifb.instruction, ifb.instr_valid, ifb.done, ifb.fetch_count} !== {10'h008, 9'h000, 1'b0, 1'b1, 16'd8}) begin
            errors++;
            $display("FAIL b_done pc=%h ir=%h v=%b d=%b cnt=%0d want pc=008 ir=000 v=0 d=1 cnt=8",
                     ifb.pc, ifb.instruction, ifb.instr_valid, ifb.done, ifb.fetch_count);
        end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checks++;
        if ({ifb.pc, ifb.done, ifb.fetch_count} !== {10'h000, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL b_restart pc=%h d=%b cnt=%0d want pc=000 d=0 cnt=0",
                     ifb.pc, ifb.done, ifb.fetch_count);
        end
        tick();
        checks++;
        if ({ifb.pc, ifb.instruction, ifb.instr_valid} !== {10'h001, 9'h041, 1'b1}) begin
            errors++;
            $display("FAIL b_refetch pc=%h ir=%h v=%b want pc=001 ir=041 v=1",
                     ifb.pc, ifb.instruction, ifb.instr_valid);
        end
    endtask

    task automatic test_wrap_saturate();
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        br_c = 1'b1;
        tgt_c = 10'h3FF;
        tick();
        br_c = 1'b0;
        tick();
        checks++;
        if ({ifc.pc, ifc.instruction, ifc.instr_valid, ifc.fetch_count} !== {10'h000, 9'h15A, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL c_wrap pc=%h ir=%h v=%b cnt=%0d want pc=000 ir=15A v=1 cnt=1",
                     ifc.pc, ifc.instruction, ifc.instr_valid, ifc.fetch_count);
        end
        tick();
        tick();
        tick();
        checks++;
        if ({ifc.pc, ifc.instruction, ifc.instr_valid, ifc.done, ifc.fetch_count} !== {10'h003, 9'h1A3, 1'b1, 1'b0, 2'd3}) begin
            errors++;
            $display("FAIL c_saturate pc=%h ir=%h v=%b d=%b cnt=%0d want pc=003 ir=1A3 v=1 d=0 cnt=3",
                     ifc.pc, ifc.instruction, ifc.instr_valid, ifc.done, ifc.fetch_count);
        end
        tick();
        checks++;
        if ({ifc.pc, ifc.instr_valid, ifc.done, ifc.fetch_count} !== {10'h003, 1'b0, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL c_done pc=%h v=%b d=%b cnt=%0d want pc=003 v=0 d=1 cnt=3",
                     ifc.pc, ifc.instr_valid, ifc.done, ifc.fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_branch_stall();
        test_prog_end();
        test_reset_midrun();
        test_done_restart();
        test_wrap_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
